// File: rtl/uart_status_tx_if.sv
// Command handshake bundle between a status producer and uart_status_tx.
//   cmd_valid  : producer has a command on cmd_ctrl/cmd_value
//   cmd_ctrl   : 4-bit control code to report
//   cmd_value  : 4-bit value code to report
//   cmd_ready  : transmitter holding buffer is empty
// A transfer happens on a rising edge where cmd_valid and cmd_ready are both high.
interface uart_status_tx_if;
    logic       cmd_valid;
    logic [3:0] cmd_ctrl;
    logic [3:0] cmd_value;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_ctrl,
        output cmd_value,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ctrl,
        input  cmd_value,
        output cmd_ready
    );
endinterface

// File: rtl/uart_status_tx.sv
// Board-to-host status transmitter: frames a {ctrl, value} command as
// HEADER, payload, checksum and shifts each byte out as 8N1 on uart_tx.
// A one-entry holding buffer lets the next command queue during a frame.
// Ports:
//   sys_clk     : system clock
//   sys_rst     : asynchronous active-low reset
//   cmd         : command handshake (slave side)
//   uart_tx     : serial line, idles high
//   busy        : high while a frame is on the line
//   frame_done  : one-cycle pulse at the end of each frame's last stop bit
module uart_status_tx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115_200,
    parameter logic [7:0]  HEADER   = 8'h55
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    uart_status_tx_if.slave   cmd,
    output logic              uart_tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic             buf_full, buf_full_nxt;
    logic [7:0]       buf_data, buf_data_nxt;
    logic [7:0]       payload, payload_nxt;
    logic [1:0]       bidx, bidx_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic             consume;
    logic             tx_c;
    logic             busy_c;
    logic             done_c;
    logic             done_d;
    logic             accept;
    logic             bit_end;
    logic [7:0]       cur_byte;
    logic             rst_meta;
    logic             rst_sync;

    // Reset synchronizer: assertion is immediate, release is aligned to sys_clk.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign accept  = cmd.cmd_valid & cmd.cmd_ready;
    assign bit_end = (baud_cnt == BIT_LAST);

    // Byte currently being serialized; checksum wraps mod 256.
    always_comb begin
        cur_byte = HEADER;
        case (bidx)
            2'd0:    cur_byte = HEADER;
            2'd1:    cur_byte = payload;
            default: cur_byte = 8'(HEADER + payload);
        endcase
    end

    // Holding buffer: a new accept wins over the consume that empties it.
    always_comb begin
        buf_full_nxt = buf_full;
        buf_data_nxt = buf_data;
        if (accept) begin
            buf_full_nxt = 1'b1;
            buf_data_nxt = {cmd.cmd_ctrl, cmd.cmd_value};
        end else if (consume) begin
            buf_full_nxt = 1'b0;
        end
    end

    // Next-state and line value; outputs are registered from these one cycle later.
    always_comb begin
        state_nxt    = state;
        payload_nxt  = payload;
        bidx_nxt     = bidx;
        bit_cnt_nxt  = bit_cnt;
        baud_cnt_nxt = baud_cnt;
        consume      = 1'b0;
        done_c       = 1'b0;
        tx_c         = 1'b1;
        busy_c       = 1'b1;

        case (state)
            IDLE: begin
                busy_c       = 1'b0;
                baud_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                if (buf_full) begin
                    payload_nxt = buf_data;
                    bidx_nxt    = 2'd0;
                    consume     = 1'b1;
                    state_nxt   = START;
                end
            end
            START: begin
                tx_c = 1'b0;
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    state_nxt    = DATA;
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                tx_c = cur_byte[bit_cnt];
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                tx_c = 1'b1;
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    if (bidx != 2'd2) begin
                        bidx_nxt  = bidx + 2'd1;
                        state_nxt = START;
                    end else begin
                        done_c = 1'b1;
                        // Queued command starts with no idle cycle between frames.
                        if (buf_full) begin
                            payload_nxt = buf_data;
                            bidx_nxt    = 2'd0;
                            consume     = 1'b1;
                            state_nxt   = START;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, buffer and registered outputs.
    always_ff @(posedge sys_clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state         <= IDLE;
            buf_full      <= 1'b0;
            buf_data      <= '0;
            payload       <= '0;
            bidx          <= '0;
            bit_cnt       <= '0;
            baud_cnt      <= '0;
            uart_tx       <= 1'b1;
            busy          <= 1'b0;
            done_d        <= 1'b0;
            frame_done    <= 1'b0;
            cmd.cmd_ready <= 1'b1;
        end else begin
            state         <= state_nxt;
            buf_full      <= buf_full_nxt;
            buf_data      <= buf_data_nxt;
            payload       <= payload_nxt;
            bidx          <= bidx_nxt;
            bit_cnt       <= bit_cnt_nxt;
            baud_cnt      <= baud_cnt_nxt;
            uart_tx       <= tx_c;
            busy          <= busy_c;
            done_d        <= done_c;
            frame_done    <= done_d;
            cmd.cmd_ready <= ~buf_full_nxt;
        end
    end

endmodule

// File: tb/tb_uart_status_tx.sv
// Self-checking bench for uart_status_tx: line decoder, busy/frame_done
// trackers, table-driven frames, queued/backpressure and mid-frame reset.
module tb_uart_status_tx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115_200;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int FRAME    = 30 * BIT_CYC;
    localparam logic [7:0] HDR = 8'h55;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic uart_tx;
    logic busy;
    logic frame_done;

    uart_status_tx_if cif ();

    uart_status_tx dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cmd        (cif),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         st;
        bit         ok;
    } rx_t;

    typedef struct {
        logic [3:0] ctrl;
        logic [3:0] value;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } vec_t;

    rx_t        byte_q[$];
    int         fd_q[$];
    int         busy_q[$];
    logic [7:0] exp_q[$];
    int         brun    = 0;
    int         low_cnt = 0;
    bit         mon_en  = 1'b0;
    bit         mon_busy = 1'b0;
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    // Reference model: frame bytes straight from the framing rules.
    task automatic push_model(input logic [3:0] c, input logic [3:0] v);
        int b1;
        b1 = int'(c) * 16 + int'(v);
        exp_q.push_back(HDR);
        exp_q.push_back(8'(b1));
        exp_q.push_back(8'((int'(HDR) + b1) % 256));
    endtask

    task automatic clear_obs();
        byte_q.delete();
        fd_q.delete();
        busy_q.delete();
        exp_q.delete();
        brun    = 0;
        low_cnt = 0;
    endtask

    // 8N1 line decoder sampling at mid-bit; start cycle is the falling edge index.
    initial begin
        int         st;
        logic [7:0] d;
        bit         ok;
        forever begin
            @(negedge sys_clk);
            if (mon_en && sys_rst === 1'b1 && uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                st = cyc;
                ok = 1'b1;
                d  = '0;
                repeat (BIT_CYC / 2) @(negedge sys_clk);
                if (uart_tx !== 1'b0) ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (BIT_CYC) @(negedge sys_clk);
                    d[k] = uart_tx;
                end
                repeat (BIT_CYC) @(negedge sys_clk);
                if (uart_tx !== 1'b1) ok = 1'b0;
                if (mon_en) byte_q.push_back('{data: d, st: st, ok: ok});
                mon_busy = 1'b0;
            end
        end
    end

    // busy run lengths, frame_done times and line-low cycles.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                brun++;
            end else if (brun != 0) begin
                busy_q.push_back(brun);
                brun = 0;
            end
            if (frame_done === 1'b1) fd_q.push_back(cyc);
            if (uart_tx !== 1'b1) low_cnt++;
        end
    end

    // Present a command and hold it until accepted; hs is the handshake edge index.
    task automatic send(input logic [3:0] c, input logic [3:0] v, input int budget, output int hs);
        int n;
        @(negedge sys_clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_ctrl  = c;
        cif.cmd_value = v;
        n = 0;
        while (cif.cmd_ready !== 1'b1 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk_bit("handshake accepted within budget", cif.cmd_ready, 1'b1);
        hs = cyc + 1;
        @(negedge sys_clk);
        cif.cmd_valid = 1'b0;
        cif.cmd_ctrl  = 4'($urandom);
        cif.cmd_value = 4'($urandom);
    endtask

    task automatic check_bytes(input string tag, input int t0);
        chk({tag, " byte count"}, byte_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < byte_q.size()) begin
                chk($sformatf("%s byte%0d data", tag, i), int'(byte_q[i].data), int'(exp_q[i]));
                chk($sformatf("%s byte%0d start", tag, i), byte_q[i].st, t0 + i * 10 * BIT_CYC);
                chk_bit($sformatf("%s byte%0d framing", tag, i), byte_q[i].ok, 1'b1);
            end
        end
    endtask

    initial begin
        vec_t       vec[4];
        int         hs, hs1, hs2, hs3, t, n;
        logic [3:0] rv, vm;
        logic [7:0] b1;

        vec[0] = '{ctrl: 4'h2, value: 4'h1, b0: 8'h55, b1: 8'h21, b2: 8'h76};
        vec[1] = '{ctrl: 4'hF, value: 4'hF, b0: 8'h55, b1: 8'hFF, b2: 8'h54};
        vec[2] = '{ctrl: 4'h9, value: 4'h0, b0: 8'h55, b1: 8'h90, b2: 8'hE5};
        vec[3] = '{ctrl: 4'h4, value: 4'h3, b0: 8'h55, b1: 8'h43, b2: 8'h98};

        // Reset and idle.
        cif.cmd_valid = 1'b0;
        cif.cmd_ctrl  = 4'h0;
        cif.cmd_value = 4'h0;
        sys_rst = 1'b0;
        repeat (10) @(negedge sys_clk);
        chk_bit("reset uart_tx", uart_tx, 1'b1);
        chk_bit("reset busy", busy, 1'b0);
        chk_bit("reset frame_done", frame_done, 1'b0);
        chk_bit("reset cmd_ready", cif.cmd_ready, 1'b1);
        sys_rst = 1'b1;
        clear_obs();
        mon_en = 1'b1;
        repeat (1000) @(negedge sys_clk);
        chk("idle line low cycles", low_cnt, 0);
        chk("idle frame_done pulses", fd_q.size(), 0);
        chk("idle busy cycles", brun + busy_q.size(), 0);
        chk("idle decoded bytes", byte_q.size(), 0);
        chk_bit("idle cmd_ready", cif.cmd_ready, 1'b1);

        // Single frames from the table, including checksum wrap.
        for (int i = 0; i < 2; i++) begin
            clear_obs();
            exp_q.push_back(vec[i].b0);
            exp_q.push_back(vec[i].b1);
            exp_q.push_back(vec[i].b2);
            send(vec[i].ctrl, vec[i].value, 10, hs);
            repeat (FRAME + 40) @(negedge sys_clk);
            check_bytes($sformatf("vec%0d", i), hs + 2);
            chk($sformatf("vec%0d frame_done count", i), fd_q.size(), 1);
            chk($sformatf("vec%0d frame_done time", i), (fd_q.size() > 0) ? fd_q[0] : -1, hs + 2 + FRAME);
            chk($sformatf("vec%0d busy runs", i), busy_q.size(), 1);
            chk($sformatf("vec%0d busy length", i), (busy_q.size() > 0) ? busy_q[0] : -1, FRAME);
        end

        // Queued frames plus backpressured third command.
        clear_obs();
        exp_q.push_back(vec[2].b0);
        exp_q.push_back(vec[2].b1);
        exp_q.push_back(vec[2].b2);
        exp_q.push_back(vec[3].b0);
        exp_q.push_back(vec[3].b1);
        exp_q.push_back(vec[3].b2);
        rv = 4'($urandom);
        push_model(4'h8, rv);
        send(vec[2].ctrl, vec[2].value, 10, hs1);
        chk_bit("queue ready low after load", cif.cmd_ready, 1'b0);
        @(negedge sys_clk);
        chk_bit("queue ready back at frame start", cif.cmd_ready, 1'b1);
        send(vec[3].ctrl, vec[3].value, 10, hs2);
        chk_bit("queue ready low while both occupied", cif.cmd_ready, 1'b0);
        send(4'h8, rv, 2 * FRAME, hs3);
        chk("backpressure accept edge", hs3, hs1 + 2 + FRAME);
        repeat (2 * FRAME + 40) @(negedge sys_clk);
        check_bytes("queued", hs1 + 2);
        chk("queued frame_done count", fd_q.size(), 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("queued frame_done%0d time", k), (fd_q.size() > k) ? fd_q[k] : -1,
                hs1 + 2 + (k + 1) * FRAME);
        chk("queued busy runs", busy_q.size(), 1);
        chk("queued busy length", (busy_q.size() > 0) ? busy_q[0] : -1, 3 * FRAME);

        // Mid-frame reset during B1 bit 3 with a command queued behind it.
        clear_obs();
        vm = 4'($urandom) & 4'h7;
        b1 = {4'h5, vm};
        send(4'h5, vm, 10, hs);
        send(4'hA, 4'($urandom), 10, hs2);
        t = hs + 2 + 10 * BIT_CYC + 4 * BIT_CYC + BIT_CYC / 2;
        while (cyc < t) @(negedge sys_clk);
        chk_bit("line at B1 bit3 before reset", uart_tx, b1[3]);
        mon_en = 1'b0;
        #2 sys_rst = 1'b0;
        #1;
        chk_bit("async reset uart_tx", uart_tx, 1'b1);
        chk_bit("async reset busy", busy, 1'b0);
        chk_bit("async reset cmd_ready", cif.cmd_ready, 1'b1);
        repeat (10) @(negedge sys_clk);
        sys_rst = 1'b1;
        n = 0;
        while (mon_busy && n < 6000) begin
            @(negedge sys_clk);
            n++;
        end
        chk_bit("decoder drained", mon_busy, 1'b0);
        clear_obs();
        mon_en = 1'b1;
        repeat (2000) @(negedge sys_clk);
        chk("post-reset line low cycles", low_cnt, 0);
        chk("post-reset frame_done pulses", fd_q.size(), 0);
        chk("post-reset busy cycles", brun + busy_q.size(), 0);
        chk_bit("post-reset cmd_ready", cif.cmd_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
